// File: rtl/subdiv_pkg.sv
// subdiv_pkg: shared widths, RAM address map helpers for the subdivision pipeline
package subdiv_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int OBJ_VERT_BASE = 2;
    localparam int DEF_MAX_NEIGHBOR_COUNT = 10;
    localparam int COORD_WIDTH = 32;
    localparam int SUM_WIDTH = COORD_WIDTH + 4;

    function automatic logic [ADDR_WIDTH-1:0] nbr_base(input logic [31:0] v, input int unsigned max_n);
        logic [31:0] a;
        a = (v - 32'd1) * max_n;
        return a[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] obj_vert_addr(input logic [31:0] v);
        logic [31:0] a;
        a = 32'(OBJ_VERT_BASE) + (v - 32'd1) * 32'd3;
        return a[ADDR_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/nbr_gather_if.sv
// nbr_gather_if: valid/ready record stream of per-vertex neighbor sums
interface nbr_gather_if;
    import subdiv_pkg::*;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_vertex;
    logic [3:0]           out_count;
    logic [SUM_WIDTH-1:0] out_sum_x;
    logic [SUM_WIDTH-1:0] out_sum_y;
    logic [SUM_WIDTH-1:0] out_sum_z;
    modport master(output out_valid, out_vertex, out_count, out_sum_x, out_sum_y, out_sum_z, input out_ready);
    modport slave(input out_valid, out_vertex, out_count, out_sum_x, out_sum_y, out_sum_z, output out_ready);
endinterface

// File: rtl/nbr_gather_vec3_accum.sv
// vec3_accum: three sign-extending coordinate accumulators, one axis added per cycle
module vec3_accum
    import subdiv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   add_en,
    input  logic [1:0]             sel,
    input  logic [COORD_WIDTH-1:0] data,
    output logic [SUM_WIDTH-1:0]   sum_x,
    output logic [SUM_WIDTH-1:0]   sum_y,
    output logic [SUM_WIDTH-1:0]   sum_z
);
    logic [SUM_WIDTH-1:0] ext;
    assign ext = {{(SUM_WIDTH - COORD_WIDTH){data[COORD_WIDTH-1]}}, data};
    always_ff @(negedge clk) begin
        if (rst || clear) begin
            sum_x <= '0;
            sum_y <= '0;
            sum_z <= '0;
        end else if (add_en) begin
            if (sel == 2'd0) sum_x <= sum_x + ext;
            if (sel == 2'd1) sum_y <= sum_y + ext;
            if (sel == 2'd2) sum_z <= sum_z + ext;
        end
    end
endmodule

// File: rtl/nbr_gather.sv
// nbr_gather: walks per-vertex neighbor lists and streams summed neighbor coordinates
module nbr_gather
    import subdiv_pkg::*;
#(
    parameter int MAX_NEIGHBOR_COUNT = DEF_MAX_NEIGHBOR_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    output logic                  RAM_OBJ_EN,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [31:0]           RAM_OBJ_Di,
    input  logic [31:0]           RAM_OBJ_Do,
    output logic                  RAM_NBR_EN,
    output logic [3:0]            RAM_NBR_WE,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [31:0]           RAM_NBR_Di,
    input  logic [31:0]           RAM_NBR_Do,
    nbr_gather_if.master          rec,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, NCOUNT, NIDX, CX, CY, CZ, EMIT, DONE} state_t;
    state_t                state;
    logic [31:0]           v;
    logic [3:0]            cnt, idx, acc, idx_n, cnt_c;
    logic [ADDR_WIDTH-1:0] base;
    logic                  en, clamp, bad_id, last, step;
    assign RAM_OBJ_EN = en;
    assign RAM_NBR_EN = en;
    assign RAM_OBJ_WE = '0;
    assign RAM_NBR_WE = '0;
    assign RAM_OBJ_Di = '0;
    assign RAM_NBR_Di = '0;
    assign rec.out_vertex = v;
    assign rec.out_count = acc;
    always_comb begin
        clamp  = RAM_NBR_Do[3:0] > 4'(MAX_NEIGHBOR_COUNT - 1);
        cnt_c  = clamp ? 4'(MAX_NEIGHBOR_COUNT - 1) : RAM_NBR_Do[3:0];
        bad_id = RAM_NBR_Do == '0 || RAM_NBR_Do > vertex_count;
        idx_n  = idx + 4'd1;
        last   = idx_n == cnt;
        step   = state == CZ || (state == NIDX && bad_id);
    end
    vec3_accum u_accum (
        .clk,
        .rst,
        .clear (state == NCOUNT),
        .add_en(state inside {CX, CY, CZ}),
        .sel   (state == CX ? 2'd0 : state == CY ? 2'd1 : 2'd2),
        .data  (RAM_OBJ_Do),
        .sum_x (rec.out_sum_x),
        .sum_y (rec.out_sum_y),
        .sum_z (rec.out_sum_z)
    );
    always_ff @(negedge clk) begin
        if (rst) begin
            state         <= IDLE;
            v             <= '0;
            cnt           <= '0;
            idx           <= '0;
            acc           <= '0;
            base          <= '0;
            en            <= 1'b0;
            RAM_NBR_A     <= '0;
            RAM_OBJ_A     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            rec.out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err <= 1'b0;
                    if (vertex_count == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        v         <= 32'd1;
                        base      <= nbr_base(32'd1, MAX_NEIGHBOR_COUNT);
                        RAM_NBR_A <= nbr_base(32'd1, MAX_NEIGHBOR_COUNT);
                        en        <= 1'b1;
                        busy      <= 1'b1;
                        state     <= NCOUNT;
                    end
                end
                NCOUNT: begin
                    cnt <= cnt_c;
                    idx <= '0;
                    acc <= '0;
                    if (clamp) err <= 1'b1;
                    if (cnt_c == '0) begin
                        rec.out_valid <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        RAM_NBR_A <= base + ADDR_WIDTH'(1);
                        state     <= NIDX;
                    end
                end
                NIDX: if (bad_id) err <= 1'b1;
                    else begin
                        RAM_OBJ_A <= obj_vert_addr(RAM_NBR_Do);
                        state     <= CX;
                    end
                CX, CY: begin
                    RAM_OBJ_A <= RAM_OBJ_A + ADDR_WIDTH'(1);
                    state     <= state == CX ? CY : CZ;
                end
                CZ: acc <= acc + 4'd1;
                EMIT: if (rec.out_ready) begin
                    rec.out_valid <= 1'b0;
                    if (v == vertex_count) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        v         <= v + 32'd1;
                        base      <= nbr_base(v + 32'd1, MAX_NEIGHBOR_COUNT);
                        RAM_NBR_A <= nbr_base(v + 32'd1, MAX_NEIGHBOR_COUNT);
                        state     <= NCOUNT;
                    end
                end
                default: state <= IDLE;
            endcase
            // invalid ids advance the list walk exactly like a completed neighbor, minus the add
            if (step) begin
                idx <= idx_n;
                if (last) begin
                    rec.out_valid <= 1'b1;
                    state         <= EMIT;
                end else begin
                    RAM_NBR_A <= base + ADDR_WIDTH'(idx_n) + ADDR_WIDTH'(1);
                    state     <= NIDX;
                end
            end
        end
    end
endmodule

// File: tb/tb_nbr_gather.sv
// tb_nbr_gather: table vectors, hand-written corner sequences and randomized passes vs a list-walking model
module tb_nbr_gather;
    import subdiv_pkg::*;
    localparam int MAXN = 10;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] vertex_count = '0;
    logic obj_en, nbr_en;
    logic [3:0] obj_we, nbr_we;
    logic [ADDR_WIDTH-1:0] obj_a, nbr_a;
    logic [31:0] obj_di, nbr_di;
    logic [31:0] obj_do = '0, nbr_do = '0;
    logic busy, done, err;
    nbr_gather_if rec ();

    nbr_gather #(.MAX_NEIGHBOR_COUNT(MAXN)) dut (
        .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count),
        .RAM_OBJ_EN(obj_en), .RAM_OBJ_WE(obj_we), .RAM_OBJ_A(obj_a), .RAM_OBJ_Di(obj_di), .RAM_OBJ_Do(obj_do),
        .RAM_NBR_EN(nbr_en), .RAM_NBR_WE(nbr_we), .RAM_NBR_A(nbr_a), .RAM_NBR_Di(nbr_di), .RAM_NBR_Do(nbr_do),
        .rec(rec), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] nbr_mem [0:1023];
    logic [31:0] obj_mem [0:1023];
    always @(posedge clk) begin
        if (nbr_en) nbr_do <= nbr_mem[nbr_a[9:0]];
        if (obj_en) obj_do <= obj_mem[obj_a[9:0]];
    end

    typedef struct {
        logic [31:0] vertex;
        logic [3:0]  count;
        logic [35:0] sx, sy, sz;
    } rec_t;

    typedef struct {
        logic [31:0] word;
        int unsigned ids [9];
        int          exp_count;
        longint      exp_sx, exp_sy, exp_sz;
        bit          exp_err;
    } vec_t;

    rec_t exp_q[$], got_q[$];
    logic exp_err;
    int n_checks = 0, n_fail = 0;
    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] t36(input longint x);
        return x[35:0];
    endfunction

    function automatic int nb(input int v);
        return (v - 1) * MAXN;
    endfunction

    function automatic int oa(input int v);
        return 2 + (v - 1) * 3;
    endfunction

    function automatic rec_t cur();
        rec_t r;
        r.vertex = rec.out_vertex;
        r.count  = rec.out_count;
        r.sx     = rec.out_sum_x;
        r.sy     = rec.out_sum_y;
        r.sz     = rec.out_sum_z;
        return r;
    endfunction

    task automatic check_rec(input string tag, input rec_t g, input rec_t e);
        check({tag, "_vertex"}, 64'(g.vertex), 64'(e.vertex));
        check({tag, "_count"}, 64'(g.count), 64'(e.count));
        check({tag, "_sum_x"}, 64'(g.sx), 64'(e.sx));
        check({tag, "_sum_y"}, 64'(g.sy), 64'(e.sy));
        check({tag, "_sum_z"}, 64'(g.sz), 64'(e.sz));
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            nbr_mem[i] = '0;
            obj_mem[i] = '0;
        end
    endtask

    task automatic set_coord(input int v, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        obj_mem[oa(v)] = x;
        obj_mem[oa(v) + 1] = y;
        obj_mem[oa(v) + 2] = z;
    endtask

    task automatic set_list(input int v, input logic [31:0] word, input int unsigned ids [9]);
        nbr_mem[nb(v)] = word;
        for (int i = 0; i < 9; i++) nbr_mem[nb(v) + 1 + i] = ids[i];
    endtask

    // Reference: walk each list as the memory describes it, clamp, skip bad ids, sum in 64 bits
    task automatic model(input int nv);
        exp_q.delete();
        exp_err = 1'b0;
        for (int v = 1; v <= nv; v++) begin
            rec_t r;
            logic [31:0] w;
            int c, k;
            longint sx, sy, sz;
            int unsigned n;
            w = nbr_mem[nb(v)];
            c = int'(w[3:0]);
            k = 0;
            sx = 0; sy = 0; sz = 0;
            if (c > MAXN - 1) begin
                c = MAXN - 1;
                exp_err = 1'b1;
            end
            for (int i = 1; i <= c; i++) begin
                n = nbr_mem[nb(v) + i];
                if (n == 0 || n > nv) exp_err = 1'b1;
                else begin
                    sx += longint'($signed(obj_mem[oa(int'(n))]));
                    sy += longint'($signed(obj_mem[oa(int'(n)) + 1]));
                    sz += longint'($signed(obj_mem[oa(int'(n)) + 2]));
                    k++;
                end
            end
            r.vertex = v;
            r.count  = 4'(k);
            r.sx = t36(sx);
            r.sy = t36(sy);
            r.sz = t36(sz);
            exp_q.push_back(r);
        end
    endtask

    task automatic collect(input int rdy_pct, input int limit);
        rec_t held, r;
        bit was_held, fin;
        was_held = 0;
        fin = 0;
        got_q.delete();
        for (int c = 0; c < limit && !fin; c++) begin
            @(posedge clk);
            start = 1'b0;
            if (done) fin = 1;
            else if (rec.out_valid) begin
                r = cur();
                if (was_held) check_rec("held_stable", r, held);
                rec.out_ready = $urandom_range(99) < rdy_pct;
                if (rec.out_ready) begin
                    got_q.push_back(r);
                    was_held = 0;
                end else begin
                    held = r;
                    was_held = 1;
                end
            end else rec.out_ready = 1'b0;
        end
        rec.out_ready = 1'b0;
        check("pass_done_seen", 64'(fin), 64'd1);
    endtask

    task automatic compare(input string tag);
        check({tag, "_nrec"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check_rec(tag, got_q[i], exp_q[i]);
        check({tag, "_err"}, 64'(err), 64'(exp_err));
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            start = 1'b0;
            if (rec.out_valid) return;
        end
        check("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic setup_three();
        int unsigned l1 [9] = '{2, 3, 0, 0, 0, 0, 0, 0, 0};
        int unsigned l0 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        int unsigned l3 [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        clear_mem();
        set_coord(1, 7, 8, 9);
        set_coord(2, 1, 2, 3);
        set_coord(3, 4, 5, 6);
        set_list(1, 2, l1);
        set_list(2, 0, l0);
        set_list(3, 1, l3);
        vertex_count = 3;
    endtask

    initial begin
        rec_t r0;
        logic [ADDR_WIDTH-1:0] a0, o0;
        rec.out_ready = 1'b0;
        tbl[0] = '{32'd2,  '{2, 3, 0, 0, 0, 0, 0, 0, 0}, 2, 5, -5, 500, 1'b0};
        tbl[1] = '{32'd0,  '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 0, 1'b0};
        tbl[2] = '{32'd3,  '{1, 0, 6, 0, 0, 0, 0, 0, 0}, 2, 7, -7, 700, 1'b1};
        tbl[3] = '{32'd2,  '{7, 4, 0, 0, 0, 0, 0, 0, 0}, 1, 4, -4, 400, 1'b1};
        tbl[4] = '{32'd12, '{1, 2, 3, 4, 5, 6, 1, 2, 3}, 9, 27, -27, 2700, 1'b1};
        tbl[5] = '{32'h15, '{5, 5, 5, 5, 5, 0, 0, 0, 0}, 5, 25, -25, 2500, 1'b0};
        clear_mem();
        repeat (3) @(posedge clk);
        check("rst_out_valid", 64'(rec.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_en", 64'({obj_en, nbr_en}), 64'd0);
        check("rst_addr", 64'({obj_a, nbr_a}), 64'd0);
        check("rst_vertex", 64'(rec.out_vertex), 64'd0);
        check("rst_sum_x", 64'(rec.out_sum_x), 64'd0);
        rst = 1'b0;

        // Table: vertex 1's list varies, vertices 2..6 have empty lists, vertex k sits at (k,-k,100k)
        for (int t = 0; t < 6; t++) begin
            clear_mem();
            for (int k = 1; k <= 6; k++) set_coord(k, k, -k, 100 * k);
            set_list(1, tbl[t].word, tbl[t].ids);
            vertex_count = 6;
            @(posedge clk);
            start = 1'b1;
            collect(100, 2000);
            check("tbl_nrec", 64'(got_q.size()), 64'd6);
            if (got_q.size() > 0) begin
                check("tbl_vertex", 64'(got_q[0].vertex), 64'd1);
                check("tbl_count", 64'(got_q[0].count), 64'(tbl[t].exp_count));
                check("tbl_sum_x", 64'(got_q[0].sx), 64'(t36(tbl[t].exp_sx)));
                check("tbl_sum_y", 64'(got_q[0].sy), 64'(t36(tbl[t].exp_sy)));
                check("tbl_sum_z", 64'(got_q[0].sz), 64'(t36(tbl[t].exp_sz)));
            end
            check("tbl_err", 64'(err), 64'(tbl[t].exp_err));
        end

        // Reset while walking vertex 1's list, then a clean pass
        setup_three();
        tbl[2].ids[0] = 0;
        nbr_mem[nb(1) + 1] = 0;
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        check("midrst_out_valid", 64'(rec.out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        rst = 1'b0;
        setup_three();
        model(3);
        @(posedge clk);
        start = 1'b1;
        collect(100, 2000);
        compare("after_rst");

        // Empty list for vertex 2: its record follows one cycle after its count fetch
        setup_three();
        @(posedge clk);
        start = 1'b1;
        wait_valid();
        check("v1_vertex", 64'(rec.out_vertex), 64'd1);
        check("v1_count", 64'(rec.out_count), 64'd2);
        check("v1_sum_x", 64'(rec.out_sum_x), 64'd5);
        check("v1_sum_y", 64'(rec.out_sum_y), 64'd7);
        check("v1_sum_z", 64'(rec.out_sum_z), 64'd9);
        rec.out_ready = 1'b1;
        @(posedge clk);
        rec.out_ready = 1'b0;
        check("v2_not_yet", 64'(rec.out_valid), 64'd0);
        @(posedge clk);
        check("v2_valid", 64'(rec.out_valid), 64'd1);
        check("v2_vertex", 64'(rec.out_vertex), 64'd2);
        check("v2_count", 64'(rec.out_count), 64'd0);
        check("v2_sums", 64'({rec.out_sum_x[3:0], rec.out_sum_y[3:0], rec.out_sum_z[3:0]}), 64'd0);
        collect(100, 2000);
        check("v3_nrec", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) check_rec("v3", got_q[1], '{32'd3, 4'd1, 36'd7, 36'd8, 36'd9});

        // Back-pressure: five stalled cycles in EMIT freeze record and RAM addresses
        setup_three();
        @(posedge clk);
        start = 1'b1;
        wait_valid();
        r0 = cur();
        a0 = nbr_a;
        o0 = obj_a;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            check("stall_valid", 64'(rec.out_valid), 64'd1);
            check_rec("stall", cur(), r0);
            check("stall_addr", 64'({nbr_a, obj_a}), 64'({a0, o0}));
        end
        rec.out_ready = 1'b1;
        @(posedge clk);
        rec.out_ready = 1'b0;
        check("stall_accepted", 64'(rec.out_valid), 64'd0);
        check("stall_next_base", 64'(nbr_a), 64'(nb(2)));
        collect(100, 2000);
        check("stall_rest_nrec", 64'(got_q.size()), 64'd2);

        // Nine most-negative coordinates sum exactly in 36 bits
        begin
            int unsigned l9 [9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
            clear_mem();
            set_coord(2, 32'h8000_0000, 32'h7fff_ffff, 32'hffff_ffff);
            set_list(1, 9, l9);
            vertex_count = 2;
            model(2);
            @(posedge clk);
            start = 1'b1;
            collect(60, 2000);
            compare("extreme");
            if (got_q.size() > 0) begin
                check("extreme_sum_x", 64'(got_q[0].sx), 64'(36'hB8000_0000));
                check("extreme_sum_y", 64'(got_q[0].sy), 64'(36'h47FFF_FFF7));
                check("extreme_sum_z", 64'(got_q[0].sz), 64'(36'hFFFFF_FFF7));
            end
        end

        // Zero vertices: a lone done pulse and no records
        vertex_count = 0;
        @(posedge clk);
        start = 1'b1;
        collect(100, 50);
        check("zero_nrec", 64'(got_q.size()), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        @(posedge clk);
        check("zero_done_pulse", 64'(done), 64'd0);

        // Randomized passes against the model
        for (int p = 0; p < 8; p++) begin
            int nv;
            int unsigned ids [9];
            logic [31:0] w;
            clear_mem();
            nv = $urandom_range(8, 1);
            for (int v = 1; v <= nv; v++) begin
                set_coord(v, $urandom, $urandom, $urandom);
                w = $urandom_range(99) < 70 ? 32'($urandom_range(5)) : $urandom;
                for (int i = 0; i < 9; i++)
                    ids[i] = $urandom_range(99) < 85 ? $urandom_range(nv, 1) : $urandom_range(nv + 2);
                set_list(v, w, ids);
            end
            vertex_count = nv;
            model(nv);
            @(posedge clk);
            start = 1'b1;
            collect($urandom_range(100, 30), 5000);
            compare("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
